pwm_carrier_mc: RTL
===================

// Module: pwm_carrier_mc
// PURPOSE
//  Multi-channel triangle-carrier PWM generator for the real-time converter models.
//  Produces N_CH phase-interleaved integer triangle carriers from one shared phase counter.
//  Compares each carrier with its modulation reference to form per-channel gate bits.
//  Steps once per qualified simulation step (sta && flag_fh); done_sig feeds the solver chain.
// PARAMETERS
//  N_CH      3    channel count (1..8); channel k offset = (k*4*QUARTER)/N_CH steps
//  CNT_W     16   signed carrier/reference width; requires 4*QUARTER < 2**(CNT_W-1)
//  QUARTER   83   steps per carrier quarter-period (= 1/(4*fc*dt)); carrier spans +/-QUARTER
//  DONE_LAT  12   clk cycles from sta to done_sig
//  DT_CYC    4    dead-time in clk cycles (used only with PWM_DEADTIME_EN)
// PORTS
//  clk       in   1          system clock
//  rst_n     in   1          asynchronous active-low reset
//  run       in   1          level; 1 = carriers running, 0 = idle
//  sta       in   1          simulation-step strobe (1-cycle pulse)
//  flag_fh   in   1          step qualifier; carrier advances only on sta && flag_fh
//  ref       in   N_CH*CNT_W packed signed references, ch k at [k*CNT_W +: CNT_W]
//  carrier   out  N_CH*CNT_W packed signed carrier values, same packing
//  gate      out  N_CH       upper-switch gate per channel
//  gate_n    out  N_CH       lower-switch gate per channel
//  sync      out  1          1-cycle pulse when channel 0 phase wraps to 0
//  done_sig  out  1          sta delayed DONE_LAT cycles
// BEHAVIOUR
//  - Clock clk; reset asynchronous, active-low (rst_n). Reset: ph=0, state IDLE, carrier=0,
//    gate=0, gate_n=0, sync=0, done_sig=0, delay line cleared.
//  - FSM IDLE/RUN. IDLE->RUN when run=1 (ph loaded 0). RUN->IDLE when run=0, same cycle,
//    regardless of step: carrier=0, gate=0, gate_n=0 on next clk edge.
//  - Phase ph in [0, 4*QUARTER-1]; per channel p_k = (ph + OFF_k) mod 4*QUARTER, OFF_k
//    elaboration constants. On each qualified step in RUN: outputs computed from current ph,
//    then ph <= (ph == 4*QUARTER-1) ? 0 : ph+1. Non-qualified sta (flag_fh=0) ignored.
//  - Carrier from p (Q=QUARTER): p<Q: p; p<2Q: 2Q-p; p<3Q: -(p-2Q); else p-4Q.
//    Sequence 0..Q..0..-Q..-1, period 4Q steps.
//  - gate_k = (ref_k > carrier_k), signed compare; ref>Q -> always 1; ref<=-Q -> always 0;
//    ref=Q -> 0 only on the peak step. gate_n = ~gate while RUN (no dead-time build).
//  - Latency: carrier/gate/sync registered 1 clk after qualified step, held until next step.
//  - sync asserted 1 clk coincident with carrier update where channel-0 p was 0.
//  - done_sig: shift register of sta, DONE_LAT stages, independent of run/flag_fh.
//  - sta while IDLE: no ph change; done_sig still produced.
//  - run falling and rising on consecutive cycles restarts ph at 0 (no phase memory).
// CONFIGURATION
//  PWM_DEADTIME_EN defined: per channel a DT_CYC-cycle down-counter; on any gate
//   change both gate and gate_n held 0 for DT_CYC clk, then new side asserted. Change
//   during an active dead-time restarts the count. Entry to IDLE clears counters, both 0.
//  PWM_DEADTIME_EN undefined: no counters; gate_n = ~gate in RUN, 0 in IDLE; DT_CYC unused.
// TESTING
//  - Reset: rst_n=0 mid-RUN -> all outputs 0 immediately, ph=0; release, run=1 -> restart at 0.
//  - Defaults, run=1, 332 qualified steps: ch0 0,1..83,82..0,-1..-83..-1, step 333 = 0, sync
//    on steps 1 and 333; ch1 first value 56, ch2 first value -55.
//  - sta with flag_fh=0 x10 -> carrier unchanged; done_sig pulses 12 clk after each sta.
//  - ref ch0=40: gate 1 while carrier<40, 0 at 40..83, 1 again below 40; ref=84 -> gate
//    stuck 1; ref=-83 -> stuck 0; ref=83 -> 0 only at peak.
//  - run dropped at ph=100 -> next clk carrier=0, gate=gate_n=0; run=1 -> ch0 restarts at 0.
//  - PWM_DEADTIME_EN, DT_CYC=4: gate 0->1 -> gate_n falls, 4 clk both 0, gate rises;
//    re-toggle within window -> both 0 for 4 clk from the re-toggle.

Source files
------------

// File: rtl/pwm_carrier_mc.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// pwm_carrier_mc
//   Multi-channel triangle-carrier PWM generator. One shared phase counter ph
//   drives N_CH phase-interleaved integer triangle carriers. Channel k runs
//   (k*4*QUARTER)/N_CH steps ahead of channel 0. Each carrier is compared with
//   its modulation reference to produce the gate bits. The carriers advance
//   once per qualified step (sta && flag_fh) while in RUN.
//
//   Optional feature macro: PWM_DEADTIME_EN
//     Defined   : each channel has a DT_CYC-cycle dead-time counter. On any
//                 gate change, gate and gate_n are both held low for DT_CYC
//                 clocks before the new side is asserted.
//     Undefined : gate_n = ~gate while RUN, 0 while IDLE; DT_CYC is unused.
//
// Ports
//   clk       in   1           system clock
//   rst_n     in   1           asynchronous active-low reset
//   run       in   1           level: 1 = carriers running, 0 = idle
//   sta       in   1           simulation-step strobe (1-cycle pulse)
//   flag_fh   in   1           step qualifier
//   mod_ref   in   N_CH*CNT_W  packed signed references, ch k at [k*CNT_W +: CNT_W]
//                              (the reference port is not called "ref" because
//                              that word is a SystemVerilog keyword)
//   carrier   out  N_CH*CNT_W  packed signed carrier values, same packing
//   gate      out  N_CH        upper-switch gate per channel
//   gate_n    out  N_CH        lower-switch gate per channel
//   sync      out  1           1-cycle pulse when channel 0 phase was 0
//   done_sig  out  1           sta delayed by DONE_LAT clocks
// -----------------------------------------------------------------------------
module pwm_carrier_mc #(
   parameter int N_CH     = 3,
   parameter int CNT_W    = 16,
   parameter int QUARTER  = 83,
   parameter int DONE_LAT = 12,
   parameter int DT_CYC   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    run,
   input  logic                    sta,
   input  logic                    flag_fh,
   input  logic [N_CH*CNT_W-1:0]   mod_ref,
   output logic [N_CH*CNT_W-1:0]   carrier,
   output logic [N_CH-1:0]         gate,
   output logic [N_CH-1:0]         gate_n,
   output logic                    sync,
   output logic                    done_sig
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam int                PERIOD  = 4 * QUARTER;
   localparam logic [CNT_W-1:0]  PH_LAST = CNT_W'(PERIOD - 1);

   // Reject parameter sets the arithmetic below cannot represent.
   if (N_CH < 1 || N_CH > 8 || DONE_LAT < 1 || DT_CYC < 1 ||
       PERIOD >= (1 << (CNT_W - 1))) begin : g_bad_cfg
      $error("pwm_carrier_mc: illegal parameter set");
   end

   state_t                  state;
   logic [CNT_W-1:0]        ph;
   logic [DONE_LAT-1:0]     dly;
   logic [N_CH*CNT_W-1:0]   car_nxt;
   logic [N_CH-1:0]         cmp_nxt;
   logic                    step;

   assign step     = sta & flag_fh;
   assign done_sig = dly[DONE_LAT-1];

   // Channel phase: shared ph plus a fixed offset, wrapped into [0, PERIOD).
   function automatic logic [CNT_W-1:0] phase_of(input logic [CNT_W-1:0] ph_v,
                                                 input int k);
      logic [CNT_W-1:0] p;
      p = ph_v + CNT_W'((k * PERIOD) / N_CH);
      if (p >= CNT_W'(PERIOD)) p = p - CNT_W'(PERIOD);
      return p;
   endfunction

   // Triangle: rises 0..Q, falls Q..-Q (both middle quarters are 2Q-p),
   // then rises -Q..-1.
   function automatic logic signed [CNT_W-1:0] tri_of(input logic [CNT_W-1:0] p);
      logic signed [CNT_W-1:0] ps;
      ps = signed'(p);
      if (p < CNT_W'(QUARTER))          return ps;
      else if (p < CNT_W'(3 * QUARTER)) return signed'(CNT_W'(2 * QUARTER)) - ps;
      else                              return ps - signed'(CNT_W'(PERIOD));
   endfunction

   // Next carrier and raw comparison for every channel, from the current ph.
   always_comb begin
      // NOTE: defaults first so no path through the block leaves a variable
      // unassigned, which would infer a latch.
      car_nxt = '0;
      cmp_nxt = '0;
      for (int k = 0; k < N_CH; k++) begin
         car_nxt[k*CNT_W +: CNT_W] = tri_of(phase_of(ph, k));
         cmp_nxt[k] = $signed(mod_ref[k*CNT_W +: CNT_W]) >
                      $signed(car_nxt[k*CNT_W +: CNT_W]);
      end
   end

`ifdef PWM_DEADTIME_EN
   localparam int DT_W = $clog2(DT_CYC + 1);
   logic [N_CH-1:0] tgt;                 // settled comparison result per channel
   logic [DT_W-1:0] dt_cnt [N_CH];       // remaining dead-time clocks
`endif

   // NOTE: all state here uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ph      <= '0;
         carrier <= '0;
         gate    <= '0;
         gate_n  <= '0;
         sync    <= 1'b0;
         // NOTE: the done delay line is cleared on reset so no stale sta can
         // emerge as a done_sig pulse after reset is released.
         dly     <= '0;
`ifdef PWM_DEADTIME_EN
         tgt     <= '0;
         for (int k = 0; k < N_CH; k++) dt_cnt[k] <= '0;
`endif
      end else begin
         dly  <= DONE_LAT'({dly, sta});
         sync <= 1'b0;
         case (state)
            IDLE: begin
               if (run) begin
                  state  <= RUN;
                  ph     <= '0;
                  gate_n <= '1;          // gate is 0 here, so the low side is on
               end
            end
            RUN: begin
               if (!run) begin
                  // Leaving RUN wins over any coincident step.
                  state   <= IDLE;
                  ph      <= '0;
                  carrier <= '0;
                  gate    <= '0;
                  gate_n  <= '0;
`ifdef PWM_DEADTIME_EN
                  tgt     <= '0;
                  for (int k = 0; k < N_CH; k++) dt_cnt[k] <= '0;
`endif
               end else begin
                  if (step) begin
                     ph      <= (ph == PH_LAST) ? '0 : ph + CNT_W'(1);
                     carrier <= car_nxt;
                     sync    <= (ph == '0);
`ifndef PWM_DEADTIME_EN
                     gate    <= cmp_nxt;
                     gate_n  <= ~cmp_nxt;
`endif
                  end
`ifdef PWM_DEADTIME_EN
                  for (int k = 0; k < N_CH; k++) begin
                     if (step && (cmp_nxt[k] != tgt[k])) begin
                        // A change (also mid dead-time) restarts the blanking.
                        tgt[k]    <= cmp_nxt[k];
                        dt_cnt[k] <= DT_W'(DT_CYC);
                        gate[k]   <= 1'b0;
                        gate_n[k] <= 1'b0;
                     end else if (dt_cnt[k] > DT_W'(1)) begin
                        dt_cnt[k] <= dt_cnt[k] - DT_W'(1);
                     end else if (dt_cnt[k] == DT_W'(1)) begin
                        dt_cnt[k] <= '0;
                        gate[k]   <= tgt[k];
                        gate_n[k] <= ~tgt[k];
                     end
                  end
`endif
               end
            end
         endcase
      end
   end

endmodule
